// File: rtl/change_return_sequencer_if.sv
// Return-trigger, balance and coin-dispenser signals of the change return sequencer.
// master drives the trigger, live balance and dispenser ready; slave is the sequencer.
interface change_return_sequencer_if #(
  parameter int TOTAL_BITS = 31
);
  logic                  trigger_return;
  logic [TOTAL_BITS-1:0] current_total;
  logic                  coin_ready;
  logic                  coin_valid;
  logic [2:0]            coin_sel;
  logic                  clear_total;
  logic                  busy;
  logic                  done;
  logic [TOTAL_BITS-1:0] remaining;
  logic [TOTAL_BITS-1:0] dispensed;

  modport master (
    output trigger_return, current_total, coin_ready,
    input  coin_valid, coin_sel, clear_total, busy, done, remaining, dispensed
  );

  modport slave (
    input  trigger_return, current_total, coin_ready,
    output coin_valid, coin_sel, clear_total, busy, done, remaining, dispensed
  );
endinterface

// File: rtl/change_return_sequencer.sv
// Arms on a held return request, snapshots/clears the balance, dispenses 1000/500/100 coins largest-first.
// All outputs registered; first coin valid the cycle after arm; coin_sel/remaining hold while coin_ready is low.
module change_return_sequencer #(
  parameter int TOTAL_BITS  = 31,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_BITS    = 4
) (
  input logic                      clk,
  input logic                      reset_n,
  change_return_sequencer_if.slave bus
);
  localparam logic [TOTAL_BITS-1:0] COIN_100  = TOTAL_BITS'(100);
  localparam logic [TOTAL_BITS-1:0] COIN_500  = TOTAL_BITS'(500);
  localparam logic [TOTAL_BITS-1:0] COIN_1000 = TOTAL_BITS'(1000);
  localparam logic [CNT_BITS-1:0]   HOLD_LAST = CNT_BITS'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE, WAIT_REL} state_t;

  state_t                state;
  logic [CNT_BITS-1:0]   hold_cnt;
  logic                  coin_valid_q;
  logic [2:0]            coin_sel_q;
  logic                  clear_q;
  logic                  busy_q;
  logic                  done_q;
  logic [TOTAL_BITS-1:0] remaining_q;
  logic [TOTAL_BITS-1:0] dispensed_q;
  logic [TOTAL_BITS-1:0] coin_amt;
  logic [TOTAL_BITS-1:0] rem_after;

  function automatic logic [2:0] pick_coin(input logic [TOTAL_BITS-1:0] amt);
    if (amt >= COIN_1000)     return 3'b100;
    else if (amt >= COIN_500) return 3'b010;
    else if (amt >= COIN_100) return 3'b001;
    else                      return 3'b000;
  endfunction

  always_comb begin
    coin_amt = '0;
    case (coin_sel_q)
      3'b100:  coin_amt = COIN_1000;
      3'b010:  coin_amt = COIN_500;
      3'b001:  coin_amt = COIN_100;
      default: coin_amt = '0;
    endcase
    rem_after = remaining_q - coin_amt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      coin_valid_q <= 1'b0;
      coin_sel_q   <= 3'b000;
      clear_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      remaining_q  <= '0;
      dispensed_q  <= '0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.trigger_return) begin
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            // Arm: hold_cnt stays saturated until the trigger is released in WAIT_REL.
            remaining_q <= bus.current_total;
            dispensed_q <= '0;
            clear_q     <= 1'b1;
            busy_q      <= 1'b1;
            if (bus.current_total >= COIN_100) begin
              state        <= DISPENSE;
              coin_valid_q <= 1'b1;
              coin_sel_q   <= pick_coin(bus.current_total);
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          if (bus.coin_ready) begin
            remaining_q <= rem_after;
            dispensed_q <= dispensed_q + coin_amt;
            if (rem_after < COIN_100) begin
              state        <= DONE;
              coin_valid_q <= 1'b0;
              coin_sel_q   <= 3'b000;
              done_q       <= 1'b1;
            end else begin
              coin_sel_q <= pick_coin(rem_after);
            end
          end
        end
        DONE: begin
          state  <= WAIT_REL;
          busy_q <= 1'b0;
        end
        WAIT_REL: begin
          if (!bus.trigger_return) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.coin_valid  = coin_valid_q;
  assign bus.coin_sel    = coin_sel_q;
  assign bus.clear_total = clear_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.remaining   = remaining_q;
  assign bus.dispensed   = dispensed_q;
endmodule

// File: tb/tb_change_return_sequencer.sv
// Directed bench for change_return_sequencer: expectations queued at stimulus time,
// a negedge monitor pops and compares on clear, coin handshake and done.
module tb_change_return_sequencer;
  localparam int TB = 31;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  int exp_clear_q[$];
  int exp_coin_q[$];
  int exp_done_rem_q[$];
  int exp_done_disp_q[$];

  change_return_sequencer_if #(.TOTAL_BITS(TB)) bus ();

  change_return_sequencer #(
    .TOTAL_BITS (TB),
    .HOLD_CYCLES(3),
    .CNT_BITS   (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},     int'(bus.coin_valid),  0);
    check({tag, "_sel"},       int'(bus.coin_sel),    0);
    check({tag, "_clear"},     int'(bus.clear_total), 0);
    check({tag, "_busy"},      int'(bus.busy),        0);
    check({tag, "_done"},      int'(bus.done),        0);
    check({tag, "_remaining"}, int'(bus.remaining),   0);
    check({tag, "_dispensed"}, int'(bus.dispensed),   0);
  endtask

  task automatic start_return(input int total, input int hold);
    bus.current_total  = TB'(total);
    bus.trigger_return = 1'b1;
    repeat (hold) tick();
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end
    tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.clear_total) begin
        if (exp_clear_q.size() == 0) fail_now("unexpected_clear");
        else begin
          check("clear_snapshot", int'(bus.remaining), exp_clear_q.pop_front());
          check("clear_dispensed_zero", int'(bus.dispensed), 0);
        end
      end
      if (bus.coin_valid && bus.coin_ready) begin
        if (exp_coin_q.size() == 0) fail_now("unexpected_coin");
        else check("coin_sel", int'(bus.coin_sel), exp_coin_q.pop_front());
      end
      if (bus.done) begin
        if (exp_done_rem_q.size() == 0) fail_now("unexpected_done");
        else begin
          check("done_remaining", int'(bus.remaining), exp_done_rem_q.pop_front());
          check("done_dispensed", int'(bus.dispensed), exp_done_disp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n            = 1'b0;
    bus.trigger_return = 1'b0;
    bus.current_total  = '0;
    bus.coin_ready     = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // 1: 1700 -> 1000,500,100,100 on consecutive cycles
    exp_clear_q.push_back(1700);
    exp_coin_q.push_back(4); exp_coin_q.push_back(2);
    exp_coin_q.push_back(1); exp_coin_q.push_back(1);
    exp_done_rem_q.push_back(0); exp_done_disp_q.push_back(1700);
    start_return(1700, 3);
    bus.trigger_return = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_coin_valid_consecutive", int'(bus.coin_valid), 1);
      check("t1_busy", int'(bus.busy), 1);
    end
    @(negedge clk);
    check("t1_done_after_4", int'(bus.done), 1);
    check("t1_valid_low_at_done", int'(bus.coin_valid), 0);
    tick();
    tick();
    check("t1_busy_after", int'(bus.busy), 0);

    // 2: interrupted holds never arm
    begin
      logic pat [5];
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
        bus.trigger_return = pat[i];
        tick();
        check("t2_clear", int'(bus.clear_total), 0);
        check("t2_valid", int'(bus.coin_valid), 0);
      end
    end
    bus.trigger_return = 1'b0;
    tick();

    // 3: 600 with ready low for 3 cycles on the first coin
    bus.coin_ready = 1'b0;
    exp_clear_q.push_back(600);
    exp_coin_q.push_back(2); exp_coin_q.push_back(1);
    exp_done_rem_q.push_back(0); exp_done_disp_q.push_back(600);
    start_return(600, 3);
    bus.trigger_return = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_valid", int'(bus.coin_valid), 1);
      check("t3_stall_sel", int'(bus.coin_sel), 2);
      check("t3_stall_remaining", int'(bus.remaining), 600);
      tick();
    end
    bus.coin_ready = 1'b1;
    wait_done("t3_done", 20);
    tick();

    // 4: 50 is below the smallest coin
    exp_clear_q.push_back(50);
    exp_done_rem_q.push_back(50); exp_done_disp_q.push_back(0);
    start_return(50, 3);
    bus.trigger_return = 1'b0;
    check("t4_no_coin", int'(bus.coin_valid), 0);
    wait_done("t4_done", 10);
    tick();

    // 5: reset after the first accept abandons the return
    exp_clear_q.push_back(1700);
    exp_coin_q.push_back(4);
    start_return(1700, 3);
    @(negedge clk);
    tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("t5_reset");
    tick();
    reset_n = 1'b1;
    exp_clear_q.push_back(1700);
    exp_coin_q.push_back(4); exp_coin_q.push_back(2);
    exp_coin_q.push_back(1); exp_coin_q.push_back(1);
    exp_done_rem_q.push_back(0); exp_done_disp_q.push_back(1700);
    tick();
    tick();
    check("t5_not_armed_clear", int'(bus.clear_total), 0);
    check("t5_not_armed_busy", int'(bus.busy), 0);
    tick();
    check("t5_rearm_clear", int'(bus.clear_total), 1);
    bus.trigger_return = 1'b0;
    wait_done("t5_done", 20);
    tick();

    // 6: long hold gives one return; re-arm needs release then new hold
    exp_clear_q.push_back(500);
    exp_coin_q.push_back(2);
    exp_done_rem_q.push_back(0); exp_done_disp_q.push_back(500);
    start_return(500, 20);
    check("t6_busy_while_held", int'(bus.busy), 0);
    check("t6_exp_coins_consumed", exp_coin_q.size(), 0);
    bus.trigger_return = 1'b0;
    tick();
    exp_clear_q.push_back(100);
    exp_coin_q.push_back(1);
    exp_done_rem_q.push_back(0); exp_done_disp_q.push_back(100);
    start_return(100, 3);
    bus.trigger_return = 1'b0;
    wait_done("t6_rearm_done", 20);
    repeat (3) tick();

    check("end_clear_q_empty", exp_clear_q.size(), 0);
    check("end_coin_q_empty", exp_coin_q.size(), 0);
    check("end_done_q_empty", exp_done_rem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
